// File: rtl/id_ex_stage.sv
// id_ex_stage: 2-entry ID/EX skid FIFO with output-side operand forwarding (optional via ID_EX_FORWARDING_EN)
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic        alu_src,
    input  logic        reg_write_in,
    input  logic [2:0]  alu_ctrl_in,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] InA,
    output logic [31:0] InB,
    output logic [2:0]  ALU_Control,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [15:0] stall_count
);
    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic        alu_src;
        logic        reg_write;
        logic [2:0]  alu_ctrl;
    } entry_t;

    entry_t      e0_q, e0_d, e1_q, e1_d, in_e;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        push, pop;
    logic [31:0] fwd_a, fwd_b;

    // FIFO control: e0 is always the head, e1 the entry behind it
    always_comb begin
        in_e = '{rs_data: rs_data, rt_data: rt_data, imm: imm, rs_addr: rs_addr, rt_addr: rt_addr,
                 rd_addr: rd_addr, alu_src: alu_src, reg_write: reg_write_in, alu_ctrl: alu_ctrl_in};
        in_ready = cnt_q != 2'd2;
        out_valid = cnt_q != 2'd0;
        push = in_valid && in_ready && !flush;
        pop = out_valid && out_ready;
        cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
        e0_d = pop ? (push ? in_e : e1_q) : ((push && cnt_q == 2'd0) ? in_e : e0_q);
        e1_d = (push && !pop && cnt_q == 2'd1) ? in_e : e1_q;
        stall_d = (out_valid && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

`ifdef ID_EX_FORWARDING_EN
    // forward from EX/MEM first, then MEM/WB; register 0 is never forwarded
    always_comb begin
        fwd_a = (e0_q.rs_addr != 5'd0 && exmem_reg_write && exmem_rd == e0_q.rs_addr) ? exmem_result :
                (e0_q.rs_addr != 5'd0 && memwb_reg_write && memwb_rd == e0_q.rs_addr) ? memwb_result :
                e0_q.rs_data;
        fwd_b = (e0_q.rt_addr != 5'd0 && exmem_reg_write && exmem_rd == e0_q.rt_addr) ? exmem_result :
                (e0_q.rt_addr != 5'd0 && memwb_reg_write && memwb_rd == e0_q.rt_addr) ? memwb_result :
                e0_q.rt_data;
    end
`else
    logic unused_fwd;
    // without forwarding the stored operands go straight through
    always_comb begin
        fwd_a = e0_q.rs_data;
        fwd_b = e0_q.rt_data;
        unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                       e0_q.rs_addr, e0_q.rt_addr};
    end
`endif

    // head presentation, zeroed while empty
    always_comb begin
        InA = out_valid ? fwd_a : 32'd0;
        InB = out_valid ? (e0_q.alu_src ? e0_q.imm : fwd_b) : 32'd0;
        ALU_Control = out_valid ? e0_q.alu_ctrl : 3'd0;
        out_rd = out_valid ? e0_q.rd_addr : 5'd0;
        out_reg_write = out_valid && e0_q.reg_write;
        stall_count = stall_q;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q <= '0;
            e1_q <= '0;
            stall_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
            e0_q <= e0_d;
            e1_q <= e1_d;
            stall_q <= stall_d;
        end
    end
endmodule
